// File: rtl/fetch_if.sv
// fetch_if: bundle between the instruction-fetch stage and its environment
// (hazard unit, branch resolution, instruction memory, decode stage).
//   stall, flush, target_pc, inst_in : into fetch
//   pc_out, if_id_inst, if_id_pc,
//   if_id_valid, halted, trap         : out of fetch
// Modport slave is the fetch stage; modport master is the environment driving it.
interface fetch_if #(
  parameter int unsigned bit_width = 32
);
  logic                 stall;
  logic                 flush;
  logic [bit_width-1:0] target_pc;
  logic [bit_width-1:0] inst_in;
  logic [bit_width-1:0] pc_out;
  logic [bit_width-1:0] if_id_inst;
  logic [bit_width-1:0] if_id_pc;
  logic                 if_id_valid;
  logic                 halted;
  logic                 trap;

  modport master (
    output stall, flush, target_pc, inst_in,
    input  pc_out, if_id_inst, if_id_pc, if_id_valid, halted, trap
  );

  modport slave (
    input  stall, flush, target_pc, inst_in,
    output pc_out, if_id_inst, if_id_pc, if_id_valid, halted, trap
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Holds the word-addressed PC, drives the
// IM address, and registers the combinationally-read instruction into IF/ID.
// Priority per edge: flush > stall > halted > (illegal-PC trap) > normal.
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous active-low reset
//   fif  - fetch_if.slave (stall/flush/target_pc/inst_in in; pc_out, IF/ID
//          fields, halted, trap out)
// Optional feature: define INVALID_PC_TRAP_EN to redirect PCs >= IM_DEPTH to
// TRAP_VEC with a one-cycle trap pulse; otherwise trap is tied low.
module fetch_stage #(
  parameter int unsigned          bit_width = 32,
  parameter logic [bit_width-1:0] RESET_PC  = '0,
  parameter int unsigned          IM_DEPTH  = 1024,
  parameter int unsigned          TRAP_VEC  = 254,
  parameter logic [bit_width-1:0] HLT_WORD  = bit_width'(32'hFC000000)
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.slave  fif
);

  // Parameter sanity: the trap vector must itself be a fetchable address.
  if (IM_DEPTH == 0) begin : g_bad_depth
    $error("fetch_stage: IM_DEPTH must be nonzero");
  end
  if (TRAP_VEC >= IM_DEPTH) begin : g_bad_vec
    $error("fetch_stage: TRAP_VEC must lie below IM_DEPTH");
  end

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [bit_width-1:0] pc_q, pc_d;
  logic [bit_width-1:0] inst_q, inst_d;
  logic [bit_width-1:0] ifpc_q, ifpc_d;
  logic                 valid_q, valid_d;
  logic                 trap_q, trap_d;
  logic                 oob_c;

`ifdef INVALID_PC_TRAP_EN
  assign oob_c = (pc_q >= bit_width'(IM_DEPTH));
`else
  assign oob_c = 1'b0;
`endif

  // Next-state / next-output logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    trap_d  = 1'b0;

    if (fif.flush) begin
      // Redirect wins even over stall; any wrong-path hlt is cancelled.
      pc_d    = fif.target_pc;
      inst_d  = '0;
      ifpc_d  = '0;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (fif.stall) begin
      // Hold everything (defaults).
    end else if (state_q == HALT) begin
      inst_d  = '0;
      ifpc_d  = '0;
      valid_d = 1'b0;
    end else if (oob_c) begin
      // Illegal PC: ignore IM data, inject NOP, vector to trap handler.
      inst_d  = '0;
      ifpc_d  = '0;
      valid_d = 1'b0;
      pc_d    = bit_width'(TRAP_VEC);
      trap_d  = 1'b1;
    end else begin
      inst_d  = fif.inst_in;
      ifpc_d  = pc_q;
      valid_d = 1'b1;
      if (fif.inst_in == HLT_WORD) begin
        state_d = HALT;
      end else begin
        pc_d = pc_q + bit_width'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      trap_q  <= trap_d;
    end
  end

  assign fif.pc_out      = pc_q;
  assign fif.if_id_inst  = inst_q;
  assign fif.if_id_pc    = ifpc_q;
  assign fif.if_id_valid = valid_q;
  assign fif.halted      = (state_q == HALT);
`ifdef INVALID_PC_TRAP_EN
  assign fif.trap        = trap_q;
`else
  assign fif.trap        = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: reset, sequential fetch, stall, flush
// combined with stall, hlt and recovery, PC wraparound, optional illegal-PC
// trap, and asynchronous reset mid-run.
module tb_fetch_stage;

  localparam int unsigned W = 32;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fetch_if #(.bit_width(W)) fif ();

  fetch_stage #(.bit_width(W)) dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are changed at the falling edge; outputs sampled at the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] ipc, input logic vld, input logic hlt,
                         input logic trp);
    chk({tag, ".pc_out"},      fif.pc_out,      pc);
    chk({tag, ".if_id_inst"},  fif.if_id_inst,  inst);
    chk({tag, ".if_id_pc"},    fif.if_id_pc,    ipc);
    chk({tag, ".if_id_valid"}, 32'(fif.if_id_valid), 32'(vld));
    chk({tag, ".halted"},      32'(fif.halted), 32'(hlt));
    chk({tag, ".trap"},        32'(fif.trap),   32'(trp));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    fif.stall     = 1'b0;
    fif.flush     = 1'b0;
    fif.target_pc = '0;
    fif.inst_in   = '0;

    #2;
    chk_all("reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Three sequential fetches.
    fif.inst_in = 32'h2001000A; step();
    chk_all("fetch0", 32'd1, 32'h2001000A, 32'd0, 1'b1, 1'b0, 1'b0);
    fif.inst_in = 32'h10000002; step();
    chk_all("fetch1", 32'd2, 32'h10000002, 32'd1, 1'b1, 1'b0, 1'b0);
    fif.inst_in = 32'h2002007B; step();
    chk_all("fetch2", 32'd3, 32'h2002007B, 32'd2, 1'b1, 1'b0, 1'b0);

    // Two stall cycles: everything holds even though IM data changes.
    fif.stall = 1'b1; fif.inst_in = 32'hDEADBEEF; step();
    chk_all("stall1", 32'd3, 32'h2002007B, 32'd2, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("stall2", 32'd3, 32'h2002007B, 32'd2, 1'b1, 1'b0, 1'b0);

    // Resume by fetching a hlt at pc 3.
    fif.stall = 1'b0; fif.inst_in = 32'hFC000000; step();
    chk_all("hlt", 32'd3, 32'hFC000000, 32'd3, 1'b1, 1'b1, 1'b0);
    fif.inst_in = 32'h12345678; step();
    chk_all("halted_nop1", 32'd3, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("halted_nop2", 32'd3, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);

    // Flush to 7 cancels halt.
    fif.flush = 1'b1; fif.target_pc = 32'd7; step();
    chk_all("flush7", 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    fif.flush = 1'b0; fif.inst_in = 32'h00000011; step();
    chk_all("fetch7", 32'd8, 32'h00000011, 32'd7, 1'b1, 1'b0, 1'b0);

    // Flush together with stall still redirects.
    fif.flush = 1'b1; fif.stall = 1'b1; fif.target_pc = 32'd5; step();
    chk_all("flush_stall5", 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    fif.flush = 1'b0; fif.stall = 1'b0; fif.inst_in = 32'h0000AAAA; step();
    chk_all("fetch5", 32'd6, 32'h0000AAAA, 32'd5, 1'b1, 1'b0, 1'b0);

`ifdef INVALID_PC_TRAP_EN
    // Out-of-range PC traps to 254 for one cycle.
    fif.flush = 1'b1; fif.target_pc = 32'd1024; step();
    chk_all("flush1024", 32'd1024, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    fif.flush = 1'b0; fif.inst_in = 32'hFC000000; step();
    chk_all("trap", 32'd254, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    fif.inst_in = 32'h00000033; step();
    chk_all("after_trap", 32'd255, 32'h00000033, 32'd254, 1'b1, 1'b0, 1'b0);
`else
    // No range check: high PCs fetch normally and the PC wraps to zero.
    fif.flush = 1'b1; fif.target_pc = 32'hFFFFFFFF; step();
    chk_all("flush_max", 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    fif.flush = 1'b0; fif.inst_in = 32'h00000001; step();
    chk_all("wrap", 32'd0, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
`endif

    // Reach pc 9, then reset asynchronously between clock edges.
    fif.flush = 1'b1; fif.target_pc = 32'd8; step();
    fif.flush = 1'b0; fif.inst_in = 32'h00000044; step();
    chk_all("pre_reset", 32'd9, 32'h00000044, 32'd8, 1'b1, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk_all("async_reset", 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    fif.inst_in = 32'h00000055; step();
    chk_all("post_reset", 32'd1, 32'h00000055, 32'd0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
